// File: rtl/rom_sample_sequencer.sv
// rom_sample_sequencer: walks the sample ROM at a programmable rate, hides the
// ROM read latency and presents each word on a valid/ready handshake.
// Optional feature: define SEQ_LOOP_EN for continuous (looping) playback;
// otherwise playback is one-shot and raises done at the last address.
module rom_sample_sequencer #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DATA_W    = 23,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned LAST_ADDR = 2**ADDR_W - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  rate_div,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int unsigned LAT_W = $clog2(ROM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    HOLD      = 2'd2,
    WAIT_TICK = 2'd3
  } state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    cnt_q;
  logic [DIV_W-1:0]    cnt_d;
  logic [LAT_W-1:0]    lat_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic [DATA_W-1:0]   smp_data_q;
  logic                smp_valid_q;
  logic                busy_q;
  logic                done_q;
  logic                overrun_q;

  logic                tick_c;
  logic                start_acc_c;
  logic                xfer_c;
  logic                at_last_c;

  assign tick_c      = (cnt_q == '0) && (state_q != IDLE);
  assign start_acc_c = (state_q == IDLE) && start && !stop;
  assign xfer_c      = smp_valid_q && smp_ready;
  assign at_last_c   = (rom_addr_q == ADDR_W'(LAST_ADDR));

  // Divider next value: reload on accepted start or tick, count down while active.
  always_comb begin
    cnt_d = cnt_q;
    if (start_acc_c || tick_c) begin
      cnt_d = rate_div;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  // Sample-rate divider register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Playback FSM with registered outputs; stop overrides every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      rom_addr_q  <= '0;
      smp_data_q  <= '0;
      smp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (stop) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      smp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FETCH;
            lat_q      <= '0;
            rom_addr_q <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
          end
        end
        FETCH: begin
          // A tick while still fetching is lost, not queued.
          if (tick_c) begin
            overrun_q <= 1'b1;
          end
          if (lat_q == LAT_W'(ROM_LAT)) begin
            smp_data_q  <= rom_q;
            smp_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        HOLD: begin
          if (tick_c) begin
            overrun_q <= 1'b1;
          end
          if (xfer_c) begin
            smp_valid_q <= 1'b0;
            if (at_last_c) begin
              rom_addr_q <= '0;
`ifdef SEQ_LOOP_EN
              state_q    <= WAIT_TICK;
`else
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
`endif
            end else begin
              rom_addr_q <= rom_addr_q + ADDR_W'(1);
              state_q    <= WAIT_TICK;
            end
          end
        end
        WAIT_TICK: begin
          if (tick_c) begin
            state_q <= FETCH;
            lat_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr  = rom_addr_q;
  assign smp_data  = smp_data_q;
  assign smp_valid = smp_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule
